// File: rtl/cnn_adr_pkg.sv
// Shared types and helpers for the CNN address sequencer.
package cnn_adr_pkg;

    typedef enum logic [1:0] {IDLE, X, Y, FIN} state_t;

    localparam int ADR_W_DEF = 8;
    localparam int LEN_W_DEF = 8;

    // Callers truncate the result to their own MAC width (up to 32 MACs).
    function automatic logic [31:0] onehot(input int unsigned idx);
        return 32'd1 << idx;
    endfunction

endpackage

// File: rtl/mac_sel_ring.sv
// One-hot MAC select ring: counts Y beats per MAC and rotates the select on wrap.
module mac_sel_ring
    import cnn_adr_pkg::*;
#(
    parameter int MAC_COUNT = 4,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 adv,
    input  logic [LEN_W-1:0]     y_per_mac,
    output logic [MAC_COUNT-1:0] sel_nxt,
    output logic                 wrap,
    output logic                 last
);

    logic [LEN_W-1:0]     cnt;
    logic [MAC_COUNT-1:0] sel;

    assign wrap = (cnt == y_per_mac - LEN_W'(1));
    assign last = wrap && sel[MAC_COUNT-1];

    // sel_nxt is what the select holds after this edge; the top registers it into en.
    always_comb begin
        sel_nxt = sel;
        if (clear)
            sel_nxt = MAC_COUNT'(onehot(0));
        else if (adv && wrap)
            sel_nxt = (sel << 1) | (sel >> (MAC_COUNT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sel <= '0;
        end else begin
            sel <= sel_nxt;
            if (clear)
                cnt <= '0;
            else if (adv)
                cnt <= wrap ? '0 : cnt + LEN_W'(1);
        end
    end

endmodule

// File: rtl/conv_adr_gen_stream.sv
// Address/enable sequencer for the MAC array: broadcast X phase, then per-MAC Y phase,
// with start/busy/done handshake and valid/ready backpressure.
module conv_adr_gen_stream
    import cnn_adr_pkg::*;
#(
    parameter int ADR_W     = ADR_W_DEF,
    parameter int MAC_COUNT = 4,
    parameter int LEN_W     = LEN_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [ADR_W-1:0]     x_base,
    input  logic [ADR_W-1:0]     y_base,
    input  logic [ADR_W-1:0]     stride,
    input  logic [LEN_W-1:0]     x_len,
    input  logic [LEN_W-1:0]     y_per_mac,
    output logic [ADR_W-1:0]     adr,
    output logic [MAC_COUNT-1:0] en,
    output logic                 adr_valid,
    input  logic                 adr_ready,
    output logic                 busy,
    output logic                 done
);

    state_t               state;
    logic [ADR_W-1:0]     y_base_r;
    logic [ADR_W-1:0]     stride_r;
    logic [LEN_W-1:0]     x_len_r;
    logic [LEN_W-1:0]     ypm_r;
    logic [LEN_W-1:0]     x_cnt;
    logic [MAC_COUNT-1:0] sel_nxt;
    logic                 ring_wrap;
    logic                 ring_last;

    // The ring sits at MAC 0 whenever we are not in Y, so entering Y needs no extra load.
    mac_sel_ring #(
        .MAC_COUNT (MAC_COUNT),
        .LEN_W     (LEN_W)
    ) u_ring (
        .clk       (clk),
        .rst       (rst),
        .clear     (state != Y),
        .adv       ((state == Y) && adr_ready),
        .y_per_mac (ypm_r),
        .sel_nxt   (sel_nxt),
        .wrap      (ring_wrap),
        .last      (ring_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            adr       <= '0;
            en        <= '0;
            adr_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            x_cnt     <= '0;
            y_base_r  <= '0;
            stride_r  <= '0;
            x_len_r   <= '0;
            ypm_r     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        y_base_r <= y_base;
                        stride_r <= stride;
                        x_len_r  <= x_len;
                        ypm_r    <= y_per_mac;
                        busy     <= 1'b1;
                        x_cnt    <= '0;
                        if (x_len != '0) begin
                            state     <= X;
                            adr       <= x_base;
                            en        <= '1;
                            adr_valid <= 1'b1;
                        end else if (y_per_mac != '0) begin
                            state     <= Y;
                            adr       <= y_base;
                            en        <= sel_nxt;
                            adr_valid <= 1'b1;
                        end else begin
                            state <= FIN;
                        end
                    end
                end
                X: begin
                    if (adr_ready) begin
                        if (x_cnt == x_len_r - LEN_W'(1)) begin
                            x_cnt <= '0;
                            if (ypm_r != '0) begin
                                state <= Y;
                                adr   <= y_base_r;
                                en    <= sel_nxt;
                            end else begin
                                state     <= FIN;
                                en        <= '0;
                                adr_valid <= 1'b0;
                            end
                        end else begin
                            x_cnt <= x_cnt + LEN_W'(1);
                            adr   <= adr + stride_r;
                        end
                    end
                end
                Y: begin
                    if (adr_ready) begin
                        if (ring_last) begin
                            state     <= FIN;
                            en        <= '0;
                            adr_valid <= 1'b0;
                        end else begin
                            adr <= adr + stride_r;
                            en  <= sel_nxt;
                        end
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_adr_gen_stream.sv
// Bench for conv_adr_gen_stream: expected beat lists built from base/stride/length rules.
module tb_conv_adr_gen_stream;

    localparam int ADR_W     = 8;
    localparam int MAC_COUNT = 4;
    localparam int LEN_W     = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic                 adr_ready = 1'b0;
    logic [ADR_W-1:0]     x_base = '0;
    logic [ADR_W-1:0]     y_base = '0;
    logic [ADR_W-1:0]     stride = '0;
    logic [LEN_W-1:0]     x_len = '0;
    logic [LEN_W-1:0]     y_per_mac = '0;
    logic [ADR_W-1:0]     adr;
    logic [MAC_COUNT-1:0] en;
    logic                 adr_valid;
    logic                 busy;
    logic                 done;

    int total = 0;
    int bad   = 0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    conv_adr_gen_stream #(
        .ADR_W     (ADR_W),
        .MAC_COUNT (MAC_COUNT),
        .LEN_W     (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .x_base    (x_base),
        .y_base    (y_base),
        .stride    (stride),
        .x_len     (x_len),
        .y_per_mac (y_per_mac),
        .adr       (adr),
        .en        (en),
        .adr_valid (adr_valid),
        .adr_ready (adr_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Expected beats: {en, adr}, X beats then Y beats, all addresses mod 256.
    task automatic build(input logic [7:0] xb, input logic [7:0] yb, input logic [7:0] s,
                         input int xl, input int ypm);
        exp_q.delete();
        for (int i = 0; i < xl; i++)
            exp_q.push_back({4'hF, 8'(int'(xb) + i * int'(s))});
        for (int j = 0; j < MAC_COUNT * ypm; j++)
            exp_q.push_back({4'(1 << (j / ypm)), 8'(int'(yb) + j * int'(s))});
    endtask

    task automatic launch(input logic [7:0] xb, input logic [7:0] yb, input logic [7:0] s,
                          input logic [7:0] xl, input logic [7:0] ypm, input bit hold);
        build(xb, yb, s, int'(xl), int'(ypm));
        @(negedge clk);
        x_base = xb; y_base = yb; stride = s; x_len = xl; y_per_mac = ypm;
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        // Config must have been latched; scrambling it now must not matter.
        x_base = 8'($urandom); y_base = 8'($urandom); stride = 8'($urandom);
        x_len = 8'($urandom); y_per_mac = 8'($urandom);
        chk("busy_rise", {31'b0, busy}, 1);
    endtask

    // mode 0: always ready, 1: random ready, 2: hold off 3 cycles on adr 0x12
    task automatic run(input logic [7:0] xb, input logic [7:0] yb, input logic [7:0] s,
                       input logic [7:0] xl, input logic [7:0] ypm, input int mode, input bit hold);
        int  cyc;
        int  stall_left;
        bit  rdy;
        launch(xb, yb, s, xl, ypm, hold);
        cyc = 0;
        stall_left = 3;
        while (exp_q.size() != 0 && cyc < 2000) begin
            chk("beat_valid", {31'b0, adr_valid}, 1);
            chk("beat_adr", {24'b0, adr}, {24'b0, exp_q[0][7:0]});
            chk("beat_en", {28'b0, en}, {28'b0, exp_q[0][11:8]});
            chk("beat_busy", {31'b0, busy}, 1);
            if (mode == 0)
                rdy = 1'b1;
            else if (mode == 1)
                rdy = 1'($urandom_range(0, 1));
            else if (exp_q[0][7:0] == 8'h12 && stall_left > 0) begin
                rdy = 1'b0;
                stall_left--;
            end else
                rdy = 1'b1;
            adr_ready = rdy;
            @(negedge clk);
            cyc++;
            if (rdy) void'(exp_q.pop_front());
        end
        if (cyc >= 2000) chk("beat_timeout", 0, 1);
        adr_ready = 1'($urandom_range(0, 1));
        chk("fin_valid", {31'b0, adr_valid}, 0);
        chk("fin_en", {28'b0, en}, 0);
        chk("fin_done", {31'b0, done}, 0);
        chk("fin_busy", {31'b0, busy}, 1);
        @(negedge clk);
        chk("done_pulse", {31'b0, done}, 1);
        chk("busy_fall", {31'b0, busy}, 0);
        start = 1'b0;
        @(negedge clk);
        chk("done_once", {31'b0, done}, 0);
        chk("idle_busy", {31'b0, busy}, 0);
        chk("idle_valid", {31'b0, adr_valid}, 0);
    endtask

    task automatic abort_run(input int n_beats);
        launch(8'h10, 8'h80, 8'h01, 8'd4, 8'd2, 1'b0);
        adr_ready = 1'b1;
        for (int k = 0; k < n_beats; k++) begin
            chk("pre_abort_adr", {24'b0, adr}, {24'b0, exp_q[0][7:0]});
            @(negedge clk);
            void'(exp_q.pop_front());
        end
        rst = 1'b1;
        #1;
        chk("abort_valid", {31'b0, adr_valid}, 0);
        chk("abort_en", {28'b0, en}, 0);
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_adr", {24'b0, adr}, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("abort_no_done", {31'b0, done}, 0);
            chk("abort_idle", {31'b0, adr_valid}, 0);
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_adr", {24'b0, adr}, 0);
        chk("rst_en", {28'b0, en}, 0);
        chk("rst_valid", {31'b0, adr_valid}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        rst = 1'b0;
        @(negedge clk);

        run(8'h10, 8'h80, 8'h01, 8'd4, 8'd2, 0, 1'b0);
        run(8'h10, 8'h80, 8'h01, 8'd4, 8'd2, 2, 1'b0);
        run(8'h10, 8'h80, 8'h01, 8'd0, 8'd3, 0, 1'b0);
        run(8'h10, 8'h80, 8'h01, 8'd0, 8'd0, 0, 1'b0);
        run(8'hFE, 8'hFB, 8'h03, 8'd3, 8'd2, 0, 1'b0);
        run(8'h10, 8'h80, 8'h01, 8'd4, 8'd0, 1, 1'b0);
        run(8'h10, 8'h80, 8'h01, 8'd4, 8'd2, 0, 1'b1);
        abort_run(6);
        run(8'h10, 8'h80, 8'h01, 8'd4, 8'd2, 0, 1'b0);

        for (int r = 0; r < 8; r++)
            run(8'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom_range(0, 6)), 8'($urandom_range(0, 4)), 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
